// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the Seq instruction sequencer and its
// fetch/run controller.
//   - Seq opcode constants (NO, CI, CR, JI, JR, JZ)
//   - 20-bit instruction field positions (code, dst, src)
//   - controller state encoding
//   - decode helper pulling the fields the controller needs
package seq_pkg;

  localparam int INST_W = 20;
  localparam int ADDR_W = 8;
  localparam int NDEV   = 8;
  localparam int CNT_W  = 16;

  // Opcodes
  localparam logic [3:0] OP_NO  = 4'd0;
  localparam logic [3:0] OP_CI  = 4'd1;
  localparam logic [3:0] OP_CR  = 4'd2;
  localparam logic [3:0] OP_JI  = 4'd3;
  localparam logic [3:0] OP_JR  = 4'd4;
  localparam logic [3:0] OP_JZ  = 4'd5;
  localparam logic [3:0] OP_MAX = OP_JZ;  // anything above is illegal

  // Field positions
  localparam int CODE_HI = 19;
  localparam int CODE_LO = 16;
  localparam int DST_HI  = 14;
  localparam int DST_LO  = 12;
  localparam int SRC_HI  = 1;
  localparam int SRC_LO  = 0;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } ctl_state_e;

  // Fields the controller inspects before issuing
  typedef struct packed {
    logic [3:0] code;
    logic [2:0] dst;
  } inst_dec_t;

  function automatic inst_dec_t decode(input logic [INST_W-1:0] inst);
    inst_dec_t d;
    d.code = inst[CODE_HI:CODE_LO];
    d.dst  = inst[DST_HI:DST_LO];
    return d;
  endfunction

endpackage

// File: rtl/seq_fetch_ctl_if.sv
// seq_fetch_ctl_if: ROM / Seq / device-busy bus around the fetch controller.
//   seq_next    : next address exported by Seq
//   rom_addr    : ROM address (controller drives = seq_next)
//   rom_en      : ROM read strobe, data valid the following cycle
//   rom_data    : ROM read data, held while rom_en is low
//   dev_busy    : per-device busy, bit d matches oreg_wen bit d
//   seq_inst    : instruction presented to Seq
//   seq_inst_en : one-cycle instruction valid to Seq
// master = controller side, slave = ROM/Seq/device side.
interface seq_fetch_ctl_if;
  import seq_pkg::*;

  logic [ADDR_W-1:0] seq_next;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [INST_W-1:0] rom_data;
  logic [NDEV-1:0]   dev_busy;
  logic [INST_W-1:0] seq_inst;
  logic              seq_inst_en;

  modport master (
    input  seq_next, rom_data, dev_busy,
    output rom_addr, rom_en, seq_inst, seq_inst_en
  );

  modport slave (
    output seq_next, rom_data, dev_busy,
    input  rom_addr, rom_en, seq_inst, seq_inst_en
  );

endinterface

// File: rtl/seq_issue_gate.sv
// seq_issue_gate: combinational issue qualification for one fetched
// instruction.
//   code     : opcode field
//   dst      : destination device field
//   dev_busy : per-device busy
//   legal    : opcode is a defined Seq opcode
//   stall    : legal command (CI/CR) whose target device is busy
module seq_issue_gate
  import seq_pkg::*;
(
  input  logic [3:0]      code,
  input  logic [2:0]      dst,
  input  logic [NDEV-1:0] dev_busy,
  output logic            legal,
  output logic            stall
);

  logic is_cmd;

  assign legal  = (code <= OP_MAX);
  assign is_cmd = (code == OP_CI) || (code == OP_CR);
  // Only command instructions touch a device; jumps/NO never wait.
  assign stall  = legal && is_cmd && dev_busy[dst];

endmodule

// File: rtl/seq_fetch_ctl.sv
// seq_fetch_ctl: fetch/run controller for the Seq sequencer.
// Reads instructions from a synchronous ROM at Seq's next address, presents
// each one to Seq with a one-cycle enable, stalls commands whose device is
// busy, and offers host run/step/halt, a single address breakpoint, an
// issued-instruction counter and a sticky illegal-opcode fault.
// Ports:
//   clock, reset     : clock (rising edge), async active-low reset
//   cmd_run/step/halt: single-cycle host command pulses (halt > step > run)
//   bkpt_en/addr     : address breakpoint
//   bus              : ROM/Seq/busy bus (master side)
//   state            : HALT=0 FETCH=1 ISSUE=2 FAULT=3
//   halted, fault    : state decodes
//   icount           : issued-instruction count, wraps
module seq_fetch_ctl
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  seq_fetch_ctl_if.master   bus,
  output logic [1:0]        state,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  icount
);

  ctl_state_e       st_q, st_d;
  logic             step_mode_q, step_mode_d;
  logic             bkpt_skip_q, bkpt_skip_d;
  logic             halt_req_q, halt_req_d;
  logic [CNT_W-1:0] icount_q;

  inst_dec_t dec;
  logic      legal, stall;
  logic      issue, rom_en;
  logic      halt_pend, bkpt_hit;

  assign dec = decode(bus.rom_data);

  seq_issue_gate u_gate (
    .code     (dec.code),
    .dst      (dec.dst),
    .dev_busy (bus.dev_busy),
    .legal    (legal),
    .stall    (stall)
  );

  // A halt in the current cycle counts as pending immediately so that a
  // halt during ISSUE takes effect at that same instruction boundary.
  assign halt_pend = halt_req_q | cmd_halt;

  // bkpt_skip lets execution leave a breakpoint address it halted on.
  assign bkpt_hit = bkpt_en && (bus.seq_next == bkpt_addr) && !bkpt_skip_q;

  always_comb begin
    st_d        = st_q;
    step_mode_d = step_mode_q;
    bkpt_skip_d = bkpt_skip_q;
    halt_req_d  = halt_req_q;
    rom_en      = 1'b0;
    issue       = 1'b0;
    case (st_q)
      ST_HALT: begin
        halt_req_d = 1'b0;
        if (cmd_halt) begin
          st_d = ST_HALT;
        end else if (cmd_step) begin
          st_d        = ST_FETCH;
          step_mode_d = 1'b1;
          bkpt_skip_d = 1'b1;
        end else if (cmd_run) begin
          st_d        = ST_FETCH;
          step_mode_d = 1'b0;
          bkpt_skip_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bkpt_hit || halt_pend) begin
          st_d       = ST_HALT;
          halt_req_d = 1'b0;
        end else begin
          rom_en      = 1'b1;
          st_d        = ST_ISSUE;
          bkpt_skip_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (!legal) begin
          st_d       = ST_FAULT;
          halt_req_d = 1'b0;
        end else if (stall) begin
          // Aborting leaves seq_next untouched, so resume refetches it.
          if (halt_pend) begin
            st_d       = ST_HALT;
            halt_req_d = 1'b0;
          end else begin
            halt_req_d = halt_pend;
          end
        end else begin
          issue = 1'b1;
          if (step_mode_q || halt_pend) begin
            st_d       = ST_HALT;
            halt_req_d = 1'b0;
          end else begin
            st_d = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        halt_req_d = 1'b0;
      end
      default: begin
        st_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_HALT;
      step_mode_q <= 1'b0;
      bkpt_skip_q <= 1'b0;
      halt_req_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      step_mode_q <= step_mode_d;
      bkpt_skip_q <= bkpt_skip_d;
      halt_req_q  <= halt_req_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     icount_q <= '0;
    else if (issue) icount_q <= icount_q + 1'b1;
  end

  // Outputs are decodes of registered state, so an async reset clears them
  // within the same cycle.
  assign bus.rom_addr    = bus.seq_next;
  assign bus.rom_en      = rom_en;
  assign bus.seq_inst    = (st_q == ST_ISSUE) ? bus.rom_data : '0;
  assign bus.seq_inst_en = issue;

  assign state  = st_q;
  assign halted = (st_q == ST_HALT);
  assign fault  = (st_q == ST_FAULT);
  assign icount = icount_q;

endmodule

// File: tb/tb_seq_fetch_ctl.sv
module tb_seq_fetch_ctl;
  import seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
  logic        bkpt_en = 1'b0;
  logic [7:0]  bkpt_addr = 8'h00;
  logic [1:0]  state;
  logic        halted, fault;
  logic [15:0] icount;
  logic [7:0]  busy_force = 8'h00;
  logic        busy_rand = 1'b0;
  int          cyc = 0;

  seq_fetch_ctl_if bus ();

  seq_fetch_ctl dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_run   (cmd_run),
    .cmd_step  (cmd_step),
    .cmd_halt  (cmd_halt),
    .bkpt_en   (bkpt_en),
    .bkpt_addr (bkpt_addr),
    .bus       (bus),
    .state     (state),
    .halted    (halted),
    .fault     (fault),
    .icount    (icount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment: program ROM and a minimal Seq that advances on issue.
  logic [19:0] rom [256];
  always @(posedge clock) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  always @(posedge clock or negedge reset)
    if (!reset) bus.seq_next <= 8'h00;
    else if (bus.seq_inst_en)
      bus.seq_next <= (bus.seq_inst[19:16] == OP_JI) ? bus.seq_inst[7:0] : bus.seq_next + 8'd1;
  assign bus.dev_busy = busy_force;

  // Reference model: program-order walk of the ROM.
  typedef struct { logic [19:0] inst; logic [15:0] cnt; } exp_t;
  exp_t        exp_q[$];
  int          issue_cyc[$];
  logic [7:0]  m_pc;
  logic [15:0] m_icount;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] flow(input logic [7:0] pc);
    logic [19:0] w;
    w = rom[pc];
    return (w[19:16] == OP_JI) ? w[7:0] : pc + 8'd1;
  endfunction

  task automatic exp_push();
    exp_t e;
    e.inst = rom[m_pc];
    e.cnt  = m_icount;
    exp_q.push_back(e);
    m_pc     = flow(m_pc);
    m_icount = m_icount + 16'd1;
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (busy_rand) busy_force = 8'($urandom & $urandom & $urandom);
  endtask

  task automatic cmd(input logic r, input logic s, input logic h, output int tc);
    cmd_run = r; cmd_step = s; cmd_halt = h;
    tc = cyc;
    tick();
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    m_pc = 8'h00; m_icount = 16'h0000;
    exp_q.delete(); issue_cyc.delete();
  endtask

  task automatic do_step();
    int tc;
    exp_push();
    cmd(1'b0, 1'b1, 1'b0, tc);
    wait_halt(200);
    chk("step_drain", exp_q.size(), 0);
    chk("step_pc", {24'd0, bus.seq_next}, {24'd0, m_pc});
  endtask

  task automatic do_run_bkpt(input logic [7:0] bp, output int tc);
    bit skip = 1'b1;
    int n = 0;
    bkpt_en = 1'b1; bkpt_addr = bp;
    while (n < 300) begin
      if (!skip && m_pc == bp) break;
      exp_push();
      skip = 1'b0;
      n++;
    end
    cmd(1'b1, 1'b0, 1'b0, tc);
    wait_halt(3000);
    chk("run_drain", exp_q.size(), 0);
    chk("bkpt_pc", {24'd0, bus.seq_next}, {24'd0, bp});
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rom_addr", {24'd0, bus.rom_addr}, {24'd0, bus.seq_next});
        if (state != 2'd2) chk("idle_out", {11'd0, bus.seq_inst_en, bus.seq_inst}, 32'd0);
        if (bus.seq_inst_en) begin
          issue_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_issue: got inst %05h, required no issue (cycle %0d)", bus.seq_inst, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("issue_inst", {12'd0, bus.seq_inst}, {12'd0, e.inst});
            chk("issue_icount", {16'd0, icount}, {16'd0, e.cnt});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int tc, nprog;
    logic [19:0] w;
    for (int i = 0; i < 256; i++) rom[i] = 20'h0;
    m_pc = 8'h00; m_icount = 16'h0000;

    // Reset values
    #2;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_icount", {16'd0, icount}, 32'd0);
    chk("rst_rom_en", {31'd0, bus.rom_en}, 32'd0);
    chk("rst_inst", {11'd0, bus.seq_inst_en, bus.seq_inst}, 32'd0);
    do_reset();

    // Run without stalls: CI dev2 0x5A, NO, JI 0; breakpoint at 0 stops the loop
    rom[0] = 20'h1205A; rom[1] = 20'h00000; rom[2] = 20'h30000;
    issue_cyc.delete();
    do_run_bkpt(8'h00, tc);
    chk("run_n_issue", issue_cyc.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < issue_cyc.size()) chk("run_issue_cyc", issue_cyc[i], tc + 2 + 2 * i);
    chk("run_icount", {16'd0, icount}, 32'd3);

    // Three steps, then breakpoint at 2 twice (second run must leave 2)
    bkpt_en = 1'b0;
    repeat (3) do_step();
    do_run_bkpt(8'h02, tc);
    do_run_bkpt(8'h02, tc);
    chk("bk_icount", {16'd0, icount}, {16'd0, m_icount});

    // Busy stall: CR dev5 held busy 4 ISSUE cycles; other devices busy after
    do_reset();
    bkpt_en = 1'b0;
    rom[0] = 20'h25000; rom[1] = 20'h30000;
    exp_push();
    busy_force = 8'h20;
    cmd(1'b0, 1'b1, 1'b0, tc);
    repeat (5) tick();
    busy_force = 8'hDF;
    wait_halt(20);
    busy_force = 8'h00;
    chk("stall_n_issue", issue_cyc.size(), 1);
    if (issue_cyc.size() > 0) chk("stall_issue_cyc", issue_cyc[0], tc + 6);
    chk("stall_icount", {16'd0, icount}, 32'd1);

    // Halt during stall aborts; resume refetches the same address
    do_reset();
    busy_force = 8'h20;
    cmd(1'b0, 1'b1, 1'b0, tc);
    repeat (2) tick();
    chk("hs_stalled", {30'd0, state}, 32'd2);
    cmd(1'b0, 1'b0, 1'b1, tc);
    chk("hs_state", {30'd0, state}, 32'd0);
    chk("hs_icount", {16'd0, icount}, 32'd0);
    chk("hs_pc", {24'd0, bus.seq_next}, 32'd0);
    busy_force = 8'h00;
    do_step();

    // Illegal opcode: fault is absorbing until async reset
    do_reset();
    rom[0] = 20'h00000; rom[1] = 20'h70000; rom[2] = 20'h30000;
    do_step();
    cmd(1'b1, 1'b0, 1'b0, tc);
    repeat (2) tick();
    chk("flt_state", {30'd0, state}, 32'd3);
    chk("flt_fault", {31'd0, fault}, 32'd1);
    chk("flt_rom_en", {31'd0, bus.rom_en}, 32'd0);
    cmd(1'b1, 1'b0, 1'b0, tc);
    cmd(1'b0, 1'b1, 1'b0, tc);
    chk("flt_absorb", {30'd0, state}, 32'd3);
    chk("flt_icount", {16'd0, icount}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd1);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    chk("arst_icount", {16'd0, icount}, 32'd0);
    chk("arst_outs", {10'd0, bus.rom_en, bus.seq_inst_en, bus.seq_inst}, 32'd0);
    do_reset();

    // Command priority
    rom[0] = 20'h00000; rom[1] = 20'h30000;
    cmd(1'b1, 1'b0, 1'b1, tc);
    chk("prio_run_halt", {30'd0, state}, 32'd0);
    tick();
    chk("prio_run_halt2", {30'd0, state}, 32'd0);
    issue_cyc.delete();
    exp_push();
    cmd(1'b1, 1'b1, 1'b0, tc);
    wait_halt(50);
    chk("prio_drain", exp_q.size(), 0);
    chk("prio_n_issue", issue_cyc.size(), 1);
    chk("prio_icount", {16'd0, icount}, 32'd1);

    // Counter wrap from a preloaded value
    force dut.icount_q = 16'hFFFE;
    tick();
    release dut.icount_q;
    m_icount = 16'hFFFE;
    do_step();
    do_step();
    chk("wrap_zero", {16'd0, icount}, 32'd0);
    do_step();
    chk("wrap_one", {16'd0, icount}, 32'd1);

    // Randomized program with random device busy
    do_reset();
    nprog = $urandom_range(8, 30);
    for (int i = 0; i < nprog; i++) begin
      w = 20'($urandom);
      w[19:16] = 4'($urandom_range(0, 5));
      if (w[19:16] == OP_JI) w[19:16] = OP_NO;
      rom[i] = w;
    end
    rom[nprog] = 20'h30000;
    busy_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 2) == 0) do_step();
      else do_run_bkpt(8'($urandom_range(0, nprog)), tc);
      repeat ($urandom_range(0, 3)) tick();
    end
    busy_rand = 1'b0;
    busy_force = 8'h00;
    chk("rnd_icount", {16'd0, icount}, {16'd0, m_icount});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_fetch_ctl.md
# seq_fetch_ctl

Fetch/run controller that sequences the `Seq` instruction sequencer. It reads 20-bit instructions from a synchronous program ROM at the address `Seq` exports on `next`, presents each one to `Seq` with a one-cycle `inst_en`, and stalls command instructions whose target device is busy. It exposes host run/step/halt control, a single address breakpoint, an issued-instruction counter and a sticky fault on illegal opcodes.

## Interface

Parameters: none; all widths are fixed by the `Seq` instruction format.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; low = in reset.
- `cmd_run` in 1: single-cycle pulse; start continuous execution.
- `cmd_step` in 1: single-cycle pulse; execute exactly one instruction.
- `cmd_halt` in 1: single-cycle pulse; stop at the next instruction boundary.
- `bkpt_en` in 1: breakpoint enable.
- `bkpt_addr` in 8: breakpoint address.
- `seq_next` in 8: `next` output of `Seq`.
- `rom_addr` out 8: ROM address; equals `seq_next` continuously.
- `rom_en` out 1: ROM read strobe. Data is valid the cycle after the strobe and is held while `rom_en` is low.
- `rom_data` in 20: ROM read data.
- `dev_busy` in 8: per-device busy; bit d corresponds to `oreg_wen` bit d.
- `seq_inst` out 20: instruction to `Seq`.
- `seq_inst_en` out 1: instruction valid to `Seq`.
- `state` out 2: controller state.
- `halted` out 1: 1 when `state` == HALT.
- `fault` out 1: sticky illegal-opcode flag.
- `icount` out 16: issued-instruction count.

## Operation

- States and encodings: HALT=0, FETCH=1, ISSUE=2, FAULT=3.
- **HALT**
  - `cmd_halt` present: stay in HALT.
  - Else `cmd_step`: go to FETCH with `step_mode`=1.
  - Else `cmd_run`: go to FETCH with `step_mode`=0.
  - On either departure set `bkpt_skip`=1.
- **FETCH**
  - Breakpoint hit (`bkpt_en` and `seq_next`==`bkpt_addr` and `bkpt_skip`==0): go to HALT, `rom_en`=0.
  - Pending halt request: go to HALT, `rom_en`=0.
  - Otherwise: `rom_en`=1, go to ISSUE, clear `bkpt_skip`.
- **ISSUE**: decode `rom_data[19:16]`.
  - Opcode > 5: go to FAULT, no issue.
  - CI(1)/CR(2) with `dev_busy[rom_data[14:12]]`=1: stall in ISSUE, `seq_inst_en`=0.
  - Pending halt while stalled: abort to HALT without issuing. The instruction is refetched on resume because `seq_next` has not changed.
  - Otherwise: `seq_inst_en`=1 for exactly this cycle, `icount`+1. Then go to HALT if `step_mode` or a halt is pending, else go to FETCH.
- `seq_inst` = `rom_data` in ISSUE, 0 otherwise. `seq_inst_en` is only ever 1 in ISSUE.
- **FAULT**: absorbing; only `reset` exits. `fault`=1, `rom_en`=0, `seq_inst_en`=0, commands ignored.
- Halt request: a `cmd_halt` seen in FETCH or ISSUE sets a `halt_req` flag. The flag is consumed by the next HALT entry. `cmd_run`/`cmd_step` outside HALT are ignored.
- Command priority within a single cycle: halt > step > run.
- `icount` wraps 0xFFFF -> 0x0000.

## Timing

- Reset values: `state`=HALT, `halted`=1, `fault`=0, `icount`=0, `rom_en`=0, `seq_inst`=0, `seq_inst_en`=0. Internal `step_mode`, `bkpt_skip` and `halt_req` all =0.
- Reset assertion mid-operation forces these values immediately. It does not complete an issue in flight.
- Run pulse at cycle t: FETCH at t+1 (`rom_en`=1); ISSUE at t+2 (`seq_inst_en`=1 if not stalled); FETCH at t+3.
- Throughput: one instruction per 2 cycles, plus 1 per stall cycle.
- `Seq` updates `next` at the edge ending the ISSUE cycle, so `seq_next` is valid in the following FETCH. No extra settle cycle is needed.
- A `dev_busy` deassertion in cycle s issues in cycle s (combinational check).
- Step: HALT -> FETCH -> ISSUE -> HALT, i.e. exactly one `seq_inst_en` pulse.
- `cmd_halt` during ISSUE with no stall: the instruction still issues; HALT the next cycle.

## Structure

- Shared package `seq_pkg` holds:
  - `Seq` opcode constants NO=0, CI=1, CR=2, JI=3, JR=4, JZ=5.
  - Instruction field positions: code [19:16], dst [14:12], src [1:0].
  - Controller state encodings.
- One natural sub-module, `seq_issue_gate`: combinational opcode legality check plus busy-stall decode (opcode, dst, `dev_busy` -> legal, stall).
- Everything else (FSM, flags, counter) is a single module.

## Test plan

- **Run, no stalls.** ROM 0:CI dev2 imm 0x5A, 1:NO, 2:JI 0x00. Pulse `cmd_run`. Expect `seq_inst_en` at cycles t+2, t+4, t+6; `seq_next` sequence 0, 1, 2, 0; `icount`=3 after cycle t+6.
- **Busy stall.** ROM 0:CR dev5 with `dev_busy`=0x20 held 4 cycles. Expect ISSUE held 4 cycles with `seq_inst_en`=0, then one pulse; `icount`=1.
- **Step and breakpoint.**
  - Three `cmd_step` pulses: exactly three issues and `halted`=1 between them.
  - `bkpt_en`=1, `bkpt_addr`=0x02, run: halts with `seq_next`=2 and instruction 2 not issued.
  - Run again: instruction 2 issues (skip works).
- **Halt during stall.** Stall on busy device, pulse `cmd_halt`. Expect HALT next cycle, `icount` unchanged. Resume refetches the same address.
- **Illegal opcode.** ROM 0:opcode 0x7. Expect FAULT, `fault`=1, no `seq_inst_en`, `cmd_run` ignored; async `reset` low clears all outputs to reset values within the same cycle.
- **Wrap and priority.**
  - Preload `icount` near 0xFFFF via a long loop: expect wrap to 0x0000.
  - `cmd_run`+`cmd_halt` in the same cycle: stays HALT.
  - `cmd_run`+`cmd_step` together: executes one instruction only.
